// File: rtl/mem_stream_reader_if.sv
// Memory read port and output word stream shared by mem_stream_reader and its neighbours.
// master drives reads and output words; slave is the memory/consumer side.
interface mem_stream_reader_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 7
);
    logic                  mem_r_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_r_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;

    modport master (
        output mem_r_en, mem_addr, out_valid, out_data, out_last,
        input  mem_r_data, out_ready
    );

    modport slave (
        input  mem_r_en, mem_addr, out_valid, out_data, out_last,
        output mem_r_data, out_ready
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Sequential memory run reader with a 2-entry valid/ready output buffer.
// Optional MEM_RD_CHECKSUM_EN adds a running XOR checksum of delivered words.
module mem_stream_reader #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
`ifdef MEM_RD_CHECKSUM_EN
    output logic [WIDTH-1:0]      checksum,
`endif
    mem_stream_reader_if.master   bus
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, last_addr_q, cur_addr;
    logic [LW-1:0]         len_q, issued_q, popped_q, len_eff;
    logic                  inflight_q;
    logic [WIDTH-1:0]      q_mem [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            cnt_q, occ;
    logic                  issue, pop, push_st, pop_st, accept;

    // A returning word is visible the cycle it arrives; it is stored only if not taken.
    always_comb begin
        len_eff       = (len > MAX_LEN) ? MAX_LEN : len;
        cur_addr      = base_q + issued_q[ADDR_WIDTH-1:0];
        occ           = cnt_q + {1'b0, inflight_q};
        bus.out_valid = (cnt_q != 2'd0) || inflight_q;
        if (cnt_q != 2'd0)
            bus.out_data = q_mem[rd_ptr_q];
        else if (inflight_q)
            bus.out_data = bus.mem_r_data;
        else
            bus.out_data = '0;
        bus.out_last  = bus.out_valid && (popped_q == len_q - 1'b1);
        pop           = bus.out_valid && bus.out_ready;
        issue         = (state_q == READ) && (issued_q != len_q)
                        && ((occ < 2'd2) || pop);
        push_st       = inflight_q && !(pop && (cnt_q == 2'd0));
        pop_st        = pop && (cnt_q != 2'd0);
        bus.mem_r_en  = issue;
        bus.mem_addr  = (state_q == READ) ? cur_addr : last_addr_q;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_eff == '0) ? FIN : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issue && (issued_q + 1'b1 == len_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && bus.out_last)
                    state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            q_mem[0]    <= '0;
            q_mem[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= len_eff;
                issued_q <= '0;
                popped_q <= '0;
            end
            if (issue) begin
                issued_q    <= issued_q + 1'b1;
                last_addr_q <= cur_addr;
            end
            if (pop)
                popped_q <= popped_q + 1'b1;
            if (push_st) begin
                q_mem[wr_ptr_q] <= bus.mem_r_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_st)
                rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_st} - {1'b0, pop_st};
        end
    end

`ifdef MEM_RD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (pop)
            checksum <= checksum ^ bus.out_data;
    end
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a registered memory model.
module tb_mem_stream_reader;
    localparam int WIDTH = 16;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [AW:0]      len = '0;
    logic             busy, done;
`ifdef MEM_RD_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] cap_data[$];
    bit               cap_last[$];
    int               cap_cyc[$];
    int               cap_addr[$];
    int done_cyc, done_cnt, valid_cnt, busy_cnt, stall_bad, max_out, busy1;
    logic [WIDTH-1:0] sum_at_done;

    mem_stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus();

    mem_stream_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .done(done),
`ifdef MEM_RD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_r_en) rdata <= mem[bus.mem_addr];
    assign bus.mem_r_data = rdata;

    task automatic run_capture(input int b, input int l, input int mode,
                               input int restart_at, input int max_cyc);
        int n_iss, n_hs, occ, tail;
        bit prev_stall, hs;
        logic [WIDTH-1:0] prev_data;
        cap_data.delete(); cap_last.delete();
        cap_cyc.delete(); cap_addr.delete();
        done_cyc = -1; done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        stall_bad = 0; max_out = 0; busy1 = 0;
        n_iss = 0; n_hs = 0; tail = -1; prev_stall = 0; prev_data = '0;
        sum_at_done = '0;
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l);
        bus.out_ready = (mode == 0);
        #1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (k == restart_at) begin
                base_addr = '0; len = 8'd2;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 2);
            #1;
            hs = bus.out_valid && bus.out_ready;
            if (k == 1 && busy) busy1 = 1;
            if (busy) busy_cnt++;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data))
                stall_bad++;
            if (bus.mem_r_en) cap_addr.push_back(int'(bus.mem_addr));
            if (bus.out_valid) valid_cnt++;
            occ = n_iss + int'(bus.mem_r_en) - n_hs - int'(hs);
            if (occ > max_out) max_out = occ;
            if (hs) begin
                cap_data.push_back(bus.out_data);
                cap_last.push_back(bus.out_last);
                cap_cyc.push_back(k);
                n_hs++;
            end
            n_iss += int'(bus.mem_r_en);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
`ifdef MEM_RD_CHECKSUM_EN
                sum_at_done = checksum;
`endif
                tail = k + 3;
            end
            if (tail >= 0 && k >= tail) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, bus.mem_r_en, bus.out_valid, bus.out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, bus.mem_r_en, bus.out_valid, bus.out_last});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr %0h data %0h want 0 0",
                     bus.mem_addr, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_capture(0, 8, 0, -1, 40);
        checks++;
        if (cap_data.size() != 8) begin
            errors++; $display("FAIL basic_count: got %0d want 8", cap_data.size());
        end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== 16'h0100 + 16'(i) || cap_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL basic_word%0d: got %h last %0d want %h last %0d",
                         i, cap_data[i], cap_last[i], 16'h0100 + 16'(i), i == 7);
            end
        end
        checks++;
        if (cap_cyc.size() != 8 || cap_cyc[0] != 2 || cap_cyc[7] != 9) begin
            errors++; $display("FAIL basic_timing: first/last hs cycle wrong, want 2 and 9");
        end
        checks++;
        if (done_cyc != 10 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done: cycle %0d count %0d want 10 1", done_cyc, done_cnt);
        end
        checks++;
        if (busy1 != 1) begin
            errors++; $display("FAIL basic_busy: got %0d want 1", busy1);
        end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{126, 127, 0, 1};
        logic [WIDTH-1:0] exp_d[4] = '{16'h017E, 16'h017F, 16'h0100, 16'h0101};
        run_capture(126, 4, 0, -1, 30);
        checks++;
        if (cap_addr.size() != 4 || cap_data.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: addr %0d data %0d want 4 4",
                     cap_addr.size(), cap_data.size());
        end
        for (int i = 0; i < 4 && i < cap_addr.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_addr[i] != exp_a[i] || cap_data[i] !== exp_d[i]
                || cap_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_word%0d: addr %0d data %h last %0d want %0d %h %0d",
                         i, cap_addr[i], cap_data[i], cap_last[i],
                         exp_a[i], exp_d[i], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        run_capture(10, 6, 1, -1, 80);
        checks++;
        if (cap_data.size() != 6) begin
            errors++; $display("FAIL bp_count: got %0d want 6", cap_data.size());
        end
        for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== 16'h010A + 16'(i)) begin
                errors++;
                $display("FAIL bp_word%0d: got %h want %h", i, cap_data[i],
                         16'h010A + 16'(i));
            end
        end
        checks++;
        if (stall_bad != 0 || max_out > 2) begin
            errors++;
            $display("FAIL bp_stall: unstable %0d outstanding %0d want 0 <=2",
                     stall_bad, max_out);
        end
        checks++;
        if (cap_cyc.size() != 6 || cap_cyc[5] != 17 || done_cyc != 18 || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done: done cycle %0d count %0d want 18 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_len_zero();
        run_capture(5, 0, 0, -1, 10);
        checks++;
        if (cap_addr.size() != 0 || valid_cnt != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL len0_idle: reads %0d valid %0d busy %0d want 0 0 0",
                     cap_addr.size(), valid_cnt, busy_cnt);
        end
        checks++;
        if (done_cyc != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL len0_done: cycle %0d count %0d want 1 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_ignored_start();
        run_capture(20, 5, 0, 3, 40);
        checks++;
        if (cap_data.size() != 5 || cap_addr.size() != 5 || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_count: words %0d reads %0d done %0d want 5 5 1",
                     cap_data.size(), cap_addr.size(), done_cnt);
        end
        for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== 16'h0114 + 16'(i)) begin
                errors++;
                $display("FAIL restart_word%0d: got %h want %h", i, cap_data[i],
                         16'h0114 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int extra = 0;
        @(negedge clk);
        start = 1'b1; base_addr = '0; len = 8'd8; bus.out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) n++;
            if (n == 3) break;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL rstmid_pre: got %0d words want 3", n);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.mem_r_en, bus.out_valid, bus.out_last} !== 5'b0
            || bus.mem_addr !== '0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outs: flags %b addr %0h data %h want 0",
                     {busy, done, bus.mem_r_en, bus.out_valid, bus.out_last},
                     bus.mem_addr, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (done || bus.out_valid || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra);
        end
        run_capture(0, 2, 0, -1, 20);
        checks++;
        if (cap_data.size() != 2 || cap_data[0] !== 16'h0100 || cap_data[1] !== 16'h0101
            || cap_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rerun: %0d words first %h want 2 words 0100 0101",
                     cap_data.size(), cap_data[0]);
        end
        checks++;
        if (done_cyc != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_done: cycle %0d count %0d want 4 1", done_cyc, done_cnt);
        end
    endtask

`ifdef MEM_RD_CHECKSUM_EN
    task automatic test_checksum();
        mem[0] = 16'h0001; mem[1] = 16'h0002;
        mem[2] = 16'h0004; mem[3] = 16'h0008;
        run_capture(0, 4, 0, -1, 30);
        checks++;
        if (sum_at_done !== 16'h000F || done_cnt != 1) begin
            errors++;
            $display("FAIL checksum: got %h done %0d want 000f 1", sum_at_done, done_cnt);
        end
    endtask
`endif

    initial begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + 16'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_ignored_start();
        test_reset_mid();
`ifdef MEM_RD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
